// File: rtl/cpu_pkg.sv
// Shared widths, control-word layout and stage-action encoding for the
// decode/execute boundary of the core.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 16;

    // Bit-field layout of the bundled control word carried into execute.
    localparam int CTRL_ALUOP_LSB  = 0;
    localparam int CTRL_ALUOP_W    = 4;
    localparam int CTRL_ALUSRC_BIT = 4;
    localparam int CTRL_REGWR_BIT  = 5;
    localparam int CTRL_MEMWR_BIT  = 6;
    localparam int CTRL_BRANCH_BIT = 7;
    localparam int CTRL_JUMP_BIT   = 8;
    localparam int CTRL_RESSRC_LSB = 9;
    localparam int CTRL_RESSRC_W   = 2;

    // What the E-stage register does on the next clock edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-slot inputs, writeback/control inputs and E-stage outputs of the
// decode->execute pipeline register, bundled as one interface.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    // Handshake: the decode slot offers an instruction with in_valid; it is
    // consumed on a rising clk edge where in_valid & in_ready are both high.
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_d;
    logic              mem_read_d;
    logic [ADDR_W-1:0] rs1_d;
    logic [ADDR_W-1:0] rs2_d;
    logic [ADDR_W-1:0] rd_d;
    logic              use_rs1_d;
    logic              use_rs2_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic [DATA_W-1:0] imm_d;
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] pcplus4_d;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall_ex;
    logic              flush;

    logic              valid_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic              mem_read_e;
    logic [ADDR_W-1:0] rs1_e;
    logic [ADDR_W-1:0] rs2_e;
    logic [ADDR_W-1:0] rd_e;
    logic [DATA_W-1:0] rd1_e;
    logic [DATA_W-1:0] rd2_e;
    logic [DATA_W-1:0] imm_e;
    logic [DATA_W-1:0] pc_e;
    logic [DATA_W-1:0] pcplus4_e;
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output in_valid, ctrl_d, mem_read_d, rs1_d, rs2_d, rd_d, use_rs1_d,
               use_rs2_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d, wb_we, wb_rd,
               wb_data, stall_ex, flush,
        input  in_ready, valid_e, ctrl_e, mem_read_e, rs1_e, rs2_e, rd_e,
               rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, hazard_stall, bubble_cnt
    );

    modport slave (
        input  in_valid, ctrl_d, mem_read_d, rs1_d, rs2_d, rd_d, use_rs1_d,
               use_rs2_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d, wb_we, wb_rd,
               wb_data, stall_ex, flush,
        output in_ready, valid_e, ctrl_e, mem_read_e, rs1_e, rs2_e, rd_e,
               rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, hazard_stall, bubble_cnt
    );

endinterface

// File: rtl/operand_bypass.sv
// Writeback forwarding for one source operand: a matching writeback index
// replaces the register-file data with the value being written this cycle.
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit;

    // Index 0 is compared like any other register.
    assign w_hit  = i_wb_we & (i_wb_rd == i_rs);
    assign o_data = w_hit ? i_wb_data : i_rd_data;

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode->execute pipeline register with load-use interlock, flush/stall
// control, writeback bypass into the E-stage operands and a bubble counter.
module decode_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int CNT_W  = cpu_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    decode_stage_pipe_if.slave  bus
);

    logic              w_hazard;
    logic              w_hold;
    stage_act_e        w_act;
    logic [ADDR_W-1:0] w_src1;
    logic [ADDR_W-1:0] w_src2;
    logic [DATA_W-1:0] w_base1;
    logic [DATA_W-1:0] w_base2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    logic              r_valid_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic              r_mem_read_e;
    logic [ADDR_W-1:0] r_rs1_e;
    logic [ADDR_W-1:0] r_rs2_e;
    logic [ADDR_W-1:0] r_rd_e;
    logic [DATA_W-1:0] r_rd1_e;
    logic [DATA_W-1:0] r_rd2_e;
    logic [DATA_W-1:0] r_imm_e;
    logic [DATA_W-1:0] r_pc_e;
    logic [DATA_W-1:0] r_pcplus4_e;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // A load sitting in E whose destination feeds the instruction in decode.
    assign w_hazard = r_valid_e & r_mem_read_e & bus.in_valid &
                      ((bus.use_rs1_d & (bus.rs1_d == r_rd_e)) |
                       (bus.use_rs2_d & (bus.rs2_d == r_rd_e)));

    assign bus.hazard_stall = w_hazard & ~bus.flush & ~bus.stall_ex;
    assign bus.in_ready     = bus.flush | (~bus.stall_ex & ~w_hazard);

    always_comb begin
        w_act = ACT_ADVANCE;
        if (bus.flush)
            w_act = ACT_FLUSH;
        else if (bus.stall_ex)
            w_act = ACT_HOLD;
        else if (w_hazard)
            w_act = ACT_BUBBLE;
    end

    // While held, each bypass watches the E-stage operand; otherwise the decode one.
    assign w_hold  = bus.stall_ex;
    assign w_src1  = w_hold ? r_rs1_e : bus.rs1_d;
    assign w_src2  = w_hold ? r_rs2_e : bus.rs2_d;
    assign w_base1 = w_hold ? r_rd1_e : bus.rd1_d;
    assign w_base2 = w_hold ? r_rd2_e : bus.rd2_d;

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_rs1 (
        .i_rs      (w_src1),
        .i_rd_data (w_base1),
        .i_wb_we   (bus.wb_we),
        .i_wb_rd   (bus.wb_rd),
        .i_wb_data (bus.wb_data),
        .o_data    (w_op1)
    );

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_rs2 (
        .i_rs      (w_src2),
        .i_rd_data (w_base2),
        .i_wb_we   (bus.wb_we),
        .i_wb_rd   (bus.wb_rd),
        .i_wb_data (bus.wb_data),
        .o_data    (w_op2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_e    <= 1'b0;
            r_ctrl_e     <= '0;
            r_mem_read_e <= 1'b0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_e      <= '0;
            r_pc_e       <= '0;
            r_pcplus4_e  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH: begin
                    r_valid_e    <= 1'b0;
                    r_ctrl_e     <= '0;
                    r_mem_read_e <= 1'b0;
                end
                ACT_HOLD: begin
                    r_rd1_e <= w_op1;
                    r_rd2_e <= w_op2;
                end
                ACT_BUBBLE: begin
                    r_valid_e    <= 1'b0;
                    r_ctrl_e     <= '0;
                    r_mem_read_e <= 1'b0;
                    if (r_bubble_cnt != {CNT_W{1'b1}})
                        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
                end
                default: begin
                    r_valid_e    <= bus.in_valid;
                    r_ctrl_e     <= bus.in_valid ? bus.ctrl_d : '0;
                    r_mem_read_e <= bus.in_valid & bus.mem_read_d;
                    r_rs1_e      <= bus.rs1_d;
                    r_rs2_e      <= bus.rs2_d;
                    r_rd_e       <= bus.rd_d;
                    r_rd1_e      <= w_op1;
                    r_rd2_e      <= w_op2;
                    r_imm_e      <= bus.imm_d;
                    r_pc_e       <= bus.pc_d;
                    r_pcplus4_e  <= bus.pcplus4_d;
                end
            endcase
        end
    end

    assign bus.valid_e    = r_valid_e;
    assign bus.ctrl_e     = r_ctrl_e;
    assign bus.mem_read_e = r_mem_read_e;
    assign bus.rs1_e      = r_rs1_e;
    assign bus.rs2_e      = r_rs2_e;
    assign bus.rd_e       = r_rd_e;
    assign bus.rd1_e      = r_rd1_e;
    assign bus.rd2_e      = r_rd2_e;
    assign bus.imm_e      = r_imm_e;
    assign bus.pc_e       = r_pc_e;
    assign bus.pcplus4_e  = r_pcplus4_e;
    assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios followed by random traffic,
// checked against an instruction-level model of what sits in the E stage.
module tb_decode_stage_pipe;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 16;
    localparam int NW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) bus ();
    decode_stage_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(2))  bus2 ();

    decode_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter copy sees identical stimulus; only its counter width differs.
    decode_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.ctrl_d     = bus.ctrl_d;
    assign bus2.mem_read_d = bus.mem_read_d;
    assign bus2.rs1_d      = bus.rs1_d;
    assign bus2.rs2_d      = bus.rs2_d;
    assign bus2.rd_d       = bus.rd_d;
    assign bus2.use_rs1_d  = bus.use_rs1_d;
    assign bus2.use_rs2_d  = bus.use_rs2_d;
    assign bus2.rd1_d      = bus.rd1_d;
    assign bus2.rd2_d      = bus.rd2_d;
    assign bus2.imm_d      = bus.imm_d;
    assign bus2.pc_d       = bus.pc_d;
    assign bus2.pcplus4_d  = bus.pcplus4_d;
    assign bus2.wb_we      = bus.wb_we;
    assign bus2.wb_rd      = bus.wb_rd;
    assign bus2.wb_data    = bus.wb_data;
    assign bus2.stall_ex   = bus.stall_ex;
    assign bus2.flush      = bus.flush;

    // ---------------- reference model / scoreboard ----------------
    // The model holds "the instruction currently in E" plus bubble totals.
    typedef struct packed {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic          mr;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [DW-1:0] pc4;
        logic          known;
        logic [NW-1:0] cnt;
        logic [1:0]    cnt2;
    } e_t;

    localparam int EW = $bits(e_t);
    logic [EW-1:0] exp_q[$];
    e_t m;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard();
        return m.valid && m.mr && bus.in_valid &&
               ((bus.use_rs1_d && bus.rs1_d == m.rd) || (bus.use_rs2_d && bus.rs2_d == m.rd));
    endfunction

    task automatic model_reset();
        m = '0;
        m.known = 1'b1;
    endtask

    task automatic model_edge(input logic hz);
        if (!rst) begin
            model_reset();
        end else if (bus.flush) begin
            m.valid = 1'b0; m.ctrl = '0; m.mr = 1'b0; m.known = 1'b0;
        end else if (bus.stall_ex) begin
            if (bus.wb_we && bus.wb_rd == m.rs1) m.d1 = bus.wb_data;
            if (bus.wb_we && bus.wb_rd == m.rs2) m.d2 = bus.wb_data;
        end else if (hz) begin
            m.valid = 1'b0; m.ctrl = '0; m.mr = 1'b0; m.known = 1'b0;
            if (m.cnt != {NW{1'b1}}) m.cnt = m.cnt + 1'b1;
            if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 1'b1;
        end else begin
            m.valid = bus.in_valid;
            m.ctrl  = bus.in_valid ? bus.ctrl_d : '0;
            m.mr    = bus.in_valid && bus.mem_read_d;
            m.rs1   = bus.rs1_d;
            m.rs2   = bus.rs2_d;
            m.rd    = bus.rd_d;
            m.d1    = (bus.wb_we && bus.wb_rd == bus.rs1_d) ? bus.wb_data : bus.rd1_d;
            m.d2    = (bus.wb_we && bus.wb_rd == bus.rs2_d) ? bus.wb_data : bus.rd2_d;
            m.imm   = bus.imm_d;
            m.pc    = bus.pc_d;
            m.pc4   = bus.pcplus4_d;
            m.known = 1'b1;
        end
    endtask

    task automatic check_e();
        e_t e;
        e = e_t'(exp_q.pop_front());
        chk("valid_e", bus.valid_e, e.valid);
        chk("ctrl_e", bus.ctrl_e, e.ctrl);
        chk("mem_read_e", bus.mem_read_e, e.mr);
        chk("bubble_cnt", bus.bubble_cnt, e.cnt);
        chk("bubble_cnt_sat", bus2.bubble_cnt, e.cnt2);
        chk("valid_e_sat", bus2.valid_e, e.valid);
        if (e.known) begin
            chk("rs1_e", bus.rs1_e, e.rs1);
            chk("rs2_e", bus.rs2_e, e.rs2);
            chk("rd_e", bus.rd_e, e.rd);
            chk("rd1_e", bus.rd1_e, e.d1);
            chk("rd2_e", bus.rd2_e, e.d2);
            chk("imm_e", bus.imm_e, e.imm);
            chk("pc_e", bus.pc_e, e.pc);
            chk("pcplus4_e", bus.pcplus4_e, e.pc4);
        end
    endtask

    // One clock: inputs are already driven; check comb outputs, then E after the edge.
    task automatic step();
        logic hz;
        #1;
        hz = model_hazard();
        chk("in_ready", bus.in_ready, bus.flush || (!bus.stall_ex && !hz));
        chk("hazard_stall", bus.hazard_stall, hz && !bus.flush && !bus.stall_ex);
        model_edge(hz);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        check_e();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.valid_e, 1'b0);
        chk({tag, "_ctrl"}, bus.ctrl_e, '0);
        chk({tag, "_mr"}, bus.mem_read_e, 1'b0);
        chk({tag, "_rs1"}, bus.rs1_e, '0);
        chk({tag, "_rs2"}, bus.rs2_e, '0);
        chk({tag, "_rd"}, bus.rd_e, '0);
        chk({tag, "_rd1"}, bus.rd1_e, '0);
        chk({tag, "_rd2"}, bus.rd2_e, '0);
        chk({tag, "_imm"}, bus.imm_e, '0);
        chk({tag, "_pc"}, bus.pc_e, '0);
        chk({tag, "_pc4"}, bus.pcplus4_e, '0);
        chk({tag, "_cnt"}, bus.bubble_cnt, '0);
        chk({tag, "_cnt_sat"}, bus2.bubble_cnt, '0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_rand(input bit quiet);
        bus.in_valid   = quiet ? 1'b1 : ($urandom_range(0, 9) < 8);
        bus.ctrl_d     = CW'($urandom);
        bus.mem_read_d = ($urandom_range(0, 9) < 4);
        bus.rs1_d      = AW'($urandom_range(0, 3));
        bus.rs2_d      = AW'($urandom_range(0, 3));
        bus.rd_d       = AW'($urandom_range(0, 3));
        bus.use_rs1_d  = 1'($urandom_range(0, 1));
        bus.use_rs2_d  = 1'($urandom_range(0, 1));
        bus.rd1_d      = $urandom;
        bus.rd2_d      = $urandom;
        bus.imm_d      = $urandom;
        bus.pc_d       = $urandom;
        bus.pcplus4_d  = bus.pc_d + 32'd4;
        bus.wb_we      = quiet ? 1'b0 : 1'($urandom_range(0, 1));
        bus.wb_rd      = AW'($urandom_range(0, 3));
        bus.wb_data    = $urandom;
        bus.stall_ex   = quiet ? 1'b0 : ($urandom_range(0, 9) < 2);
        bus.flush      = quiet ? 1'b0 : ($urandom_range(0, 9) == 0);
    endtask

    // Async reset pulse mid-cycle: outputs must clear before any clock edge.
    task automatic mid_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk_zero("async_rst");
        step();
        rst = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [CW-1:0] held_ctrl;
        logic [DW-1:0] held_pc;
        logic [NW-1:0] cnt_before;

        rst = 1'b0;
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b0);
            step();
            chk_zero("rst_hold");
        end
        rst = 1'b1;

        // First instruction after release appears one cycle later.
        drive_rand(1'b1);
        bus.mem_read_d = 1'b0;
        bus.ctrl_d = 16'h00A5;
        bus.pc_d = 32'h100;
        bus.pcplus4_d = 32'h104;
        step();
        chk("first_valid", bus.valid_e, 1'b1);
        chk("first_ctrl", bus.ctrl_e, 16'h00A5);
        chk("first_pc", bus.pc_e, 32'h100);

        // Load-use: exactly one bubble.
        drive_rand(1'b1);
        bus.mem_read_d = 1'b1;
        bus.rd_d = 4'd3;
        step();
        drive_rand(1'b1);
        bus.mem_read_d = 1'b0;
        bus.use_rs1_d = 1'b1;
        bus.rs1_d = 4'd3;
        #1;
        chk("lu_hazard_stall", bus.hazard_stall, 1'b1);
        chk("lu_in_ready", bus.in_ready, 1'b0);
        step();
        chk("lu_bubble_valid", bus.valid_e, 1'b0);
        chk("lu_bubble_cnt", bus.bubble_cnt, 16'd1);
        step();
        chk("lu_dep_valid", bus.valid_e, 1'b1);
        chk("lu_dep_rs1", bus.rs1_e, 4'd3);

        // Bypass on capture.
        drive_rand(1'b1);
        bus.rs2_d = 4'd5;
        bus.rd2_d = 32'h11;
        bus.wb_we = 1'b1;
        bus.wb_rd = 4'd5;
        bus.wb_data = 32'hDEAD;
        step();
        chk("byp_capture_rd2", bus.rd2_e, 32'hDEAD);

        // Stall refresh of a held operand.
        drive_rand(1'b1);
        bus.mem_read_d = 1'b0;
        bus.rs1_d = 4'd7;
        held_ctrl = bus.ctrl_d;
        held_pc = bus.pc_d;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            bus.stall_ex = 1'b1;
            bus.wb_we = (i == 1);
            bus.wb_rd = 4'd7;
            bus.wb_data = 32'h42;
            step();
            chk("stall_ctrl", bus.ctrl_e, held_ctrl);
            chk("stall_pc", bus.pc_e, held_pc);
            if (i >= 1) chk("stall_rd1", bus.rd1_e, 32'h42);
        end

        // Flush beats stall_ex beats hazard.
        drive_rand(1'b1);
        bus.mem_read_d = 1'b1;
        bus.rd_d = 4'd9;
        step();
        drive_rand(1'b1);
        bus.use_rs1_d = 1'b1;
        bus.rs1_d = 4'd9;
        bus.flush = 1'b1;
        bus.stall_ex = 1'b1;
        cnt_before = m.cnt;
        #1;
        chk("prio_in_ready", bus.in_ready, 1'b1);
        chk("prio_hazard_stall", bus.hazard_stall, 1'b0);
        step();
        chk("prio_valid", bus.valid_e, 1'b0);
        chk("prio_cnt", bus.bubble_cnt, cnt_before);

        // Saturation: five hazards on a clean counter.
        drive_rand(1'b1);
        mid_reset();
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            bus.mem_read_d = 1'b1;
            bus.rd_d = 4'd2;
            bus.rs1_d = 4'd2;
            bus.use_rs1_d = 1'b1;
            step();
        end
        chk("sat_cnt2", bus2.bubble_cnt, 2'd3);
        chk("sat_cnt16", bus.bubble_cnt, 16'd5);

        // Random traffic with occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'b0);
            if ($urandom_range(0, 49) == 0) mid_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
